// File: rtl/uart_debugger.sv
`default_nettype none
// ============================================================================
// uart_debugger : periodic 8N1 telemetry transmitter + single-byte command RX
// Revision 1.0
// ============================================================================
module uart_debugger #(
   parameter int DATA_WIDTH_BASE2        = 12,
   parameter int DATA_WIDTH              = 2112,
   parameter int DIVIDER_TICKS_WIDTH     = 22,
   parameter int DIVIDER_TICKS           = 2272727,
   parameter int UART_TICKS_PER_BIT_SIZE = 9,
   parameter int UART_TICKS_PER_BIT      = 434
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  debug_uart_rx_in,
   output logic [7:0]            debug_command,
   output logic                  debug_command_pulse,
   output logic                  debug_command_busy,
   output logic                  tx_out
);

   localparam logic [DIVIDER_TICKS_WIDTH-1:0]     DIV_LAST  = DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1);
   localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] BIT_LAST  = UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1);
   localparam logic [UART_TICKS_PER_BIT_SIZE-1:0] HALF_LAST = UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT / 2 - 1);
   localparam logic [DATA_WIDTH_BASE2-1:0]        BYTE_LAST = DATA_WIDTH_BASE2'(DATA_WIDTH / 8 - 1);

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [2:0] RX_WAIT_IDLE = 3'd0;
   localparam logic [2:0] RX_IDLE      = 3'd1;
   localparam logic [2:0] RX_START     = 3'd2;
   localparam logic [2:0] RX_DATA      = 3'd3;
   localparam logic [2:0] RX_STOP      = 3'd4;

   logic [DIVIDER_TICKS_WIDTH-1:0]     div_q, div_d;
   logic                               trigger;

   logic [1:0]                         tx_state_q, tx_state_d;
   logic [UART_TICKS_PER_BIT_SIZE-1:0] tx_baud_q, tx_baud_d;
   logic [2:0]                         tx_bit_q, tx_bit_d;
   logic [DATA_WIDTH_BASE2-1:0]        tx_byte_q, tx_byte_d;
   logic [DATA_WIDTH-1:0]              shadow_q, shadow_d;
   logic                               tx_q, tx_d;
   logic                               busy_q, busy_d;

   logic                               rx_meta_q, rx_sync_q;
   logic [2:0]                         rx_state_q, rx_state_d;
   logic [UART_TICKS_PER_BIT_SIZE-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]                         rx_bit_q, rx_bit_d;
   logic [7:0]                         rx_shift_q, rx_shift_d;
   logic [7:0]                         cmd_q, cmd_d;
   logic                               pulse_q, pulse_d;

   always_comb begin
      trigger = (div_q == DIV_LAST);
      div_d   = trigger ? '0 : div_q + 1'b1;
   end

   // The shadow word is consumed one bit at a time, so bit 0 is always next on the wire.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_byte_d  = tx_byte_q;
      shadow_d   = shadow_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (trigger) begin
               shadow_d   = data_in;
               tx_byte_d  = '0;
               tx_baud_d  = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_baud_q == BIT_LAST) begin
               tx_baud_d  = '0;
               tx_bit_d   = '0;
               tx_d       = shadow_q[0];
               tx_state_d = TX_DATA;
            end else begin
               tx_baud_d = tx_baud_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_baud_q == BIT_LAST) begin
               tx_baud_d = '0;
               shadow_d  = shadow_q >> 1;
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
                  tx_d     = shadow_q[1];
               end
            end else begin
               tx_baud_d = tx_baud_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_baud_q == BIT_LAST) begin
               tx_baud_d = '0;
               if (tx_byte_q < BYTE_LAST) begin
                  tx_byte_d  = tx_byte_q + 1'b1;
                  tx_d       = 1'b0;
                  tx_state_d = TX_START;
               end else begin
                  tx_d       = 1'b1;
                  busy_d     = 1'b0;
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_baud_d = tx_baud_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      cmd_d      = cmd_q;
      pulse_d    = 1'b0;
      case (rx_state_q)
         RX_WAIT_IDLE: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Mid-bit check rejects short low glitches on the line.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  cmd_d      = rx_shift_q;
                  pulse_d    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_WAIT_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         div_q      <= '0;
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_byte_q  <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         rx_meta_q  <= 1'b0;
         rx_sync_q  <= 1'b0;
         rx_state_q <= RX_WAIT_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         cmd_q      <= 8'h00;
         pulse_q    <= 1'b0;
      end else begin
         div_q      <= div_d;
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_byte_q  <= tx_byte_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         rx_meta_q  <= debug_uart_rx_in;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         cmd_q      <= cmd_d;
         pulse_q    <= pulse_d;
      end
   end

   always_ff @(posedge clk_in) begin
      shadow_q <= shadow_d;
   end

   assign tx_out              = tx_q;
   assign debug_command_busy  = busy_q;
   assign debug_command       = cmd_q;
   assign debug_command_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_debugger.sv
`default_nettype none
// ============================================================================
// tb_uart_debugger : directed + randomized self-checking bench for uart_debugger
// Revision 1.0
// ============================================================================
module tb_uart_debugger;

   localparam int DW  = 16;
   localparam int DT  = 15;
   localparam int TPB = 20;
   localparam int NB  = DW / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] data_in;
   logic          rx;
   logic [7:0]    debug_command;
   logic          debug_command_pulse;
   logic          debug_command_busy;
   logic          tx_out;

   int         compared   = 0;
   int         mismatched = 0;
   int         cyc        = 0;
   int         pulse_cnt  = 0;
   int         pulse_cyc  = 0;
   logic [7:0] pulse_cmd  = 8'h00;
   int         stop_mid   = 0;
   int         e0         = 0;
   logic [7:0] exp_cmd    = 8'h00;

   uart_debugger #(
      .DATA_WIDTH_BASE2        (5),
      .DATA_WIDTH              (DW),
      .DIVIDER_TICKS_WIDTH     (5),
      .DIVIDER_TICKS           (DT),
      .UART_TICKS_PER_BIT_SIZE (5),
      .UART_TICKS_PER_BIT      (TPB)
   ) dut (
      .clk_in              (clk),
      .reset               (reset),
      .data_in             (data_in),
      .debug_uart_rx_in    (rx),
      .debug_command       (debug_command),
      .debug_command_pulse (debug_command_pulse),
      .debug_command_busy  (debug_command_busy),
      .tx_out              (tx_out)
   );

   always #5 clk = ~clk;

   // Edge counter since reset release: after edge e it reads e+1.
   always @(posedge clk) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (debug_command_pulse === 1'b1) begin
         pulse_cnt <= pulse_cnt + 1;
         pulse_cmd <= debug_command;
         pulse_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Message start model: first trigger edge (count == DT-1) after the previous message ends.
   function automatic int next_start(input int prev);
      int e;
      e = prev + 10 * TPB * NB + 1;
      while (e % DT != DT - 1) e++;
      return e;
   endfunction

   task automatic wait_start(input int exp_e, input string tag);
      int n;
      n = 0;
      while (debug_command_busy !== 1'b1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_seen"}, {31'd0, debug_command_busy}, 32'd1);
      check({tag, "_edge"}, cyc - 1, exp_e);
      check({tag, "_tx_start"}, {31'd0, tx_out}, 32'd0);
      e0 = cyc - 1;
   endtask

   task automatic check_msg(input logic [DW-1:0] msg, input logic [DW-1:0] nxt, input string tag);
      logic [9:0] frame;
      for (int k = 0; k < NB; k++) begin
         frame = {1'b1, msg[8*k +: 8], 1'b0};
         for (int j = 0; j < 10; j++) begin
            repeat ((k == 0 && j == 0) ? TPB / 2 : TPB) @(posedge clk);
            #1;
            check($sformatf("%s_byte%0d_bit%0d", tag, k, j), {31'd0, tx_out}, {31'd0, frame[j]});
            if (k == 0 && j == 2) data_in = nxt;
         end
      end
      repeat (TPB / 2 - 1) @(posedge clk);
      #1;
      check({tag, "_busy_last"}, {31'd0, debug_command_busy}, 32'd1);
      @(posedge clk); #1;
      check({tag, "_busy_fall"}, {31'd0, debug_command_busy}, 32'd0);
      check({tag, "_tx_idle"}, {31'd0, tx_out}, 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_b);
      logic [9:0] f;
      f = {stop_b, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         rx = f[j];
         if (j == 9) stop_mid = cyc + TPB / 2;
         repeat (TPB - 1) @(negedge clk);
      end
      @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic rx_case(input logic [7:0] b, input logic stop_b, input string tag);
      int p0;
      int d;
      p0 = pulse_cnt;
      send_frame(b, stop_b);
      repeat (30) @(negedge clk);
      #1;
      if (stop_b) exp_cmd = b;
      check({tag, "_pulses"}, pulse_cnt - p0, stop_b ? 32'd1 : 32'd0);
      check({tag, "_cmd"}, {24'd0, debug_command}, {24'd0, exp_cmd});
      if (stop_b) begin
         d = pulse_cyc - stop_mid;
         check({tag, "_pulse_cmd"}, {24'd0, pulse_cmd}, {24'd0, b});
         check({tag, "_latency_ok"}, {31'd0, (d >= 0 && d <= 12)}, 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] r1, r2;
      logic [7:0]    b1, b2;
      int            n, p0;

      data_in = 16'h3130;
      rx      = 1'b1;
      reset   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("rst%0d_tx", i), {31'd0, tx_out}, 32'd1);
         check($sformatf("rst%0d_busy", i), {31'd0, debug_command_busy}, 32'd0);
         check($sformatf("rst%0d_pulse", i), {31'd0, debug_command_pulse}, 32'd0);
         check($sformatf("rst%0d_cmd", i), {24'd0, debug_command}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      r1 = DW'($urandom);
      r2 = DW'($urandom);
      wait_start(DT - 1, "m0");
      check_msg(16'h3130, 16'hFFFF, "m0");
      wait_start(next_start(e0), "m1");
      check_msg(16'hFFFF, r1, "m1");
      wait_start(next_start(e0), "m2");
      check_msg(r1, r2, "m2");
      wait_start(next_start(e0), "m3");
      check_msg(r2, r2, "m3");

      // Command receiver, with the transmitter still running alongside.
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      rx_case(8'hA5, 1'b1, "rx_a5");
      rx_case(b1, 1'b1, "rx_rand1");
      p0 = pulse_cnt;
      @(negedge clk); rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (250) @(negedge clk);
      #1;
      check("rx_glitch_pulses", pulse_cnt - p0, 32'd0);
      check("rx_glitch_cmd", {24'd0, debug_command}, {24'd0, exp_cmd});
      rx_case(8'h3C, 1'b0, "rx_frame_err");
      rx_case(8'h42, 1'b1, "rx_after_err");
      rx_case(b2, 1'b1, "rx_rand2");

      // Abort a frame mid start bit, then hold RX low forever.
      n = 0;
      while (debug_command_busy !== 1'b1 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_busy_seen", {31'd0, debug_command_busy}, 32'd1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rx    = 1'b0;
      @(posedge clk); #1;
      check("abort_tx", {31'd0, tx_out}, 32'd1);
      check("abort_busy", {31'd0, debug_command_busy}, 32'd0);
      check("abort_cmd", {24'd0, debug_command}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset   = 1'b1;
      exp_cmd = 8'h00;
      p0      = pulse_cnt;
      wait_start(DT - 1, "m_after_rst");
      repeat (600) @(negedge clk);
      #1;
      check("rx_low_pulses", pulse_cnt - p0, 32'd0);
      check("rx_low_cmd", {24'd0, debug_command}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
